// File: rtl/apb_cmd_requester_if.sv
// Command/response handshakes plus APB requester signals for apb_cmd_requester.
// Handshakes: a transfer occurs on a rising edge where valid and ready are both 1.
interface apb_cmd_requester_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic [2:0]        cmd_prot;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [3:0]        psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [2:0]        pprot;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  // FSM state: 0=IDLE 1=SETUP 2=ACCESS 3=RESP
  logic [1:0]        dbg_state;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, paddr, pwrite, pprot, pwdata, pstrb, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, paddr, pwrite, pprot, pwdata, pstrb, dbg_state
  );
endinterface

// File: rtl/apb_cmd_requester.sv
// Single-outstanding APB requester: command port -> IDLE/SETUP/ACCESS -> response port.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_cmd_requester #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_LSB     = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input logic                   pclk,
  input logic                   preset,
  apb_cmd_requester_if.master   bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;

  logic [3:0] sel_onehot;
  logic       decode_err;

  always_comb begin
    sel_onehot = 4'b0001 << bus.cmd_addr[SEL_LSB+1:SEL_LSB];
    decode_err = |bus.cmd_addr[ADDR_W-1:SEL_LSB+2];
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;
`endif

  assign bus.dbg_state = state;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.psel      <= '0;
      bus.penable   <= 1'b0;
      bus.paddr     <= '0;
      bus.pwrite    <= 1'b0;
      bus.pprot     <= '0;
      bus.pwdata    <= '0;
      bus.pstrb     <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          // cmd_ready is 1 throughout IDLE, so valid alone marks acceptance
          if (bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            if (decode_err) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state       <= SETUP;
              bus.psel    <= sel_onehot;
              bus.paddr   <= bus.cmd_addr;
              bus.pwrite  <= bus.cmd_write;
              bus.pprot   <= bus.cmd_prot;
              bus.pwdata  <= bus.cmd_wdata;
              bus.pstrb   <= bus.cmd_write ? bus.cmd_strb : '0;
            end
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          to_cnt      <= '0;
`endif
        end
        ACCESS: begin
          if (bus.pready) begin
            state         <= RESP;
            bus.psel      <= '0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
            bus.rsp_err   <= bus.pslverr;
          end
`ifdef APB_TIMEOUT_EN
          // Abort on the TIMEOUT_CYC-th stalled ACCESS cycle
          else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state         <= RESP;
            bus.psel      <= '0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_requester.sv
// Directed bench for apb_cmd_requester: APB slave model, protocol checker and
// response scoreboard fed from an expected queue.
module tb_apb_cmd_requester;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int RW     = DATA_W + 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2, S_RESP = 2'd3;

  logic pclk = 1'b0;
  logic preset = 1'b1;

  apb_cmd_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_cmd_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_LSB(5), .TIMEOUT_CYC(16)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .bus(bus)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;

  int          slv_wait  = 0;
  int          slv_cnt   = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // APB slave: inserts slv_wait stall cycles per ACCESS, then completes
  always @(negedge pclk) begin
    if (bus.penable && bus.psel != 4'b0000) begin
      if (slv_cnt < slv_wait) begin
        bus.pready = 1'b0;
        slv_cnt++;
      end else begin
        bus.pready  = 1'b1;
        bus.prdata  = slv_rdata;
        bus.pslverr = slv_err;
      end
    end else begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = '0;
      slv_cnt     = 0;
    end
  end

  always @(negedge pclk) begin
    if (!preset) begin
      check("psel_onehot0", 64'($onehot0(bus.psel)), 64'd1);
      if (bus.penable) check("penable_without_psel", 64'(bus.psel != 4'b0000), 64'd1);
    end
  end

  // Response monitor
  always @(negedge pclk) begin
    if (!preset && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got err=%0b rdata=%0h required no response",
                 bus.rsp_err, bus.rsp_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_err_rdata", 64'({bus.rsp_err, bus.rsp_rdata}), 64'(mon_exp));
      end
    end
  end

  task automatic drive_cmd(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot);
    bus.cmd_write = w;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_prot  = prot;
    bus.cmd_valid = 1'b1;
  endtask

  // Returns just after the accepting edge
  task automatic send_cmd(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot);
    int n;
    n = 0;
    @(negedge pclk);
    drive_cmd(w, addr, wdata, strb, prot);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("cmd_accept", 64'(bus.cmd_ready), 64'd1);
    @(posedge pclk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output int lat);
    lat = 0;
    while (lat < bound) begin
      @(negedge pclk);
      lat++;
      if (bus.rsp_valid) break;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b1;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;

    // Reset state
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("rst_psel",      64'(bus.psel),      64'd0);
    check("rst_penable",   64'(bus.penable),   64'd0);
    check("rst_paddr",     64'(bus.paddr),     64'd0);
    check("rst_pwdata",    64'(bus.pwdata),    64'd0);
    check("rst_pstrb",     64'(bus.pstrb),     64'd0);
    check("rst_pwrite",    64'(bus.pwrite),    64'd0);
    check("rst_pprot",     64'(bus.pprot),     64'd0);
    check("rst_state",     64'(bus.dbg_state), 64'(S_IDLE));
    @(posedge pclk);
    #1 preset = 1'b0;

    // 1: zero-wait write to slave 1; prdata is nonzero and must not leak into rdata
    slv_wait = 0; slv_rdata = 32'hDEAD_BEEF; slv_err = 1'b0;
    exp_q.push_back({1'b0, 32'h0});
    send_cmd(1'b1, 32'h24, 32'hA5A5_0001, 4'hF, 3'b010);
    @(negedge pclk);
    check("t1_setup_state", 64'(bus.dbg_state), 64'(S_SETUP));
    check("t1_setup_psel",  64'(bus.psel),      64'h2);
    check("t1_setup_pen",   64'(bus.penable),   64'd0);
    check("t1_paddr",       64'(bus.paddr),     64'h24);
    check("t1_pwdata",      64'(bus.pwdata),    64'hA5A5_0001);
    check("t1_pstrb",       64'(bus.pstrb),     64'hF);
    check("t1_pwrite",      64'(bus.pwrite),    64'd1);
    check("t1_pprot",       64'(bus.pprot),     64'h2);
    @(negedge pclk);
    check("t1_access_state", 64'(bus.dbg_state), 64'(S_ACCESS));
    check("t1_access_pen",   64'(bus.penable),   64'd1);
    check("t1_access_psel",  64'(bus.psel),      64'h2);
    @(negedge pclk);
    check("t1_rsp_valid_lat3", 64'(bus.rsp_valid), 64'd1);
    check("t1_resp_psel",      64'(bus.psel),      64'd0);
    check("t1_resp_pen",       64'(bus.penable),   64'd0);
    drain();

    // 2: read slave 3 with three wait states; APB outputs stable throughout ACCESS
    slv_wait = 3; slv_rdata = 32'h1234_5678; slv_err = 1'b0;
    exp_q.push_back({1'b0, 32'h1234_5678});
    send_cmd(1'b0, 32'h60, 32'hFFFF_FFFF, 4'hF, 3'b001);
    lat = 0; acc = 0;
    while (lat < 50) begin
      @(negedge pclk);
      lat++;
      if (bus.rsp_valid) break;
      if (bus.penable) begin
        acc++;
        check("t2_psel",   64'(bus.psel),   64'h8);
        check("t2_paddr",  64'(bus.paddr),  64'h60);
        check("t2_pwrite", 64'(bus.pwrite), 64'd0);
        check("t2_pstrb",  64'(bus.pstrb),  64'd0);
        check("t2_pprot",  64'(bus.pprot),  64'h1);
      end
    end
    check("t2_latency",      64'(lat), 64'd6);
    check("t2_access_cycles", 64'(acc), 64'd4);
    drain();

    // 3: decode error, no APB activity
    exp_q.push_back({1'b1, 32'h0});
    send_cmd(1'b0, 32'h80, 32'h0, 4'h0, 3'b000);
    lat = 0;
    while (lat < 20) begin
      @(negedge pclk);
      lat++;
      check("t3_no_psel", 64'(bus.psel), 64'd0);
      if (bus.rsp_valid) break;
    end
    check("t3_latency", 64'(lat), 64'd1);
    drain();

    // 4: slave error on write with response backpressure, then a queued command
    @(posedge pclk);
    #1 bus.rsp_ready = 1'b0;
    slv_wait = 1; slv_rdata = 32'h5555_AAAA; slv_err = 1'b1;
    exp_q.push_back({1'b1, 32'h0});
    send_cmd(1'b1, 32'h44, 32'h0BAD_F00D, 4'h3, 3'b000);
    wait_rsp(50, lat);
    check("t4_latency", 64'(lat), 64'd4);
    slv_wait = 0; slv_rdata = 32'hCAFE_0004; slv_err = 1'b0;
    exp_q.push_back({1'b0, 32'hCAFE_0004});
    drive_cmd(1'b0, 32'h00, 32'h0, 4'hF, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check("t4_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("t4_hold_err",   64'(bus.rsp_err),   64'd1);
      check("t4_hold_rdata", 64'(bus.rsp_rdata), 64'd0);
      check("t4_hold_cready", 64'(bus.cmd_ready), 64'd0);
      check("t4_hold_state", 64'(bus.dbg_state), 64'(S_RESP));
      check("t4_hold_psel",  64'(bus.psel),      64'd0);
    end
    @(posedge pclk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    check("t4_idle_cready", 64'(bus.cmd_ready), 64'd1);
    check("t4_idle_valid",  64'(bus.rsp_valid), 64'd0);
    check("t4_idle_state",  64'(bus.dbg_state), 64'(S_IDLE));
    @(posedge pclk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge pclk);
    check("t4_b2b_state", 64'(bus.dbg_state), 64'(S_SETUP));
    check("t4_b2b_psel",  64'(bus.psel),      64'h1);
    drain();

    // 5: reset while in ACCESS; the pending response is discarded
    slv_wait = 1000;
    send_cmd(1'b0, 32'h20, 32'h0, 4'h0, 3'b000);
    lat = 0;
    while (bus.dbg_state != S_ACCESS && lat < 20) begin
      @(negedge pclk);
      lat++;
    end
    repeat (2) @(negedge pclk);
    check("t5_in_access", 64'(bus.penable), 64'd1);
    preset = 1'b1;
    @(negedge pclk);
    check("t5_psel",   64'(bus.psel),      64'd0);
    check("t5_pen",    64'(bus.penable),   64'd0);
    check("t5_rvalid", 64'(bus.rsp_valid), 64'd0);
    check("t5_cready", 64'(bus.cmd_ready), 64'd1);
    check("t5_state",  64'(bus.dbg_state), 64'(S_IDLE));
    preset = 1'b0;

    // 6: slave never answers
    slv_wait = 1000;
`ifdef APB_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'h0});
    send_cmd(1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    wait_rsp(100, lat);
    check("t6_timeout_latency", 64'(lat), 64'd18);
    check("t6_psel", 64'(bus.psel), 64'd0);
    drain();
`else
    send_cmd(1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    repeat (100) @(negedge pclk);
    check("t6_state",  64'(bus.dbg_state), 64'(S_ACCESS));
    check("t6_pen",    64'(bus.penable),   64'd1);
    check("t6_psel",   64'(bus.psel),      64'h4);
    check("t6_rvalid", 64'(bus.rsp_valid), 64'd0);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
`endif

    // Recovery: zero-wait write to slave 3
    slv_wait = 0; slv_rdata = 32'h0F0F_0F0F; slv_err = 1'b0;
    exp_q.push_back({1'b0, 32'h0});
    send_cmd(1'b1, 32'h7C, 32'h1111_2222, 4'h5, 3'b100);
    @(negedge pclk);
    check("t7_psel",  64'(bus.psel),  64'h8);
    check("t7_pstrb", 64'(bus.pstrb), 64'h5);
    drain();

    repeat (3) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
